// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmitter with a runtime baud divider, optional parity,
// one or two stop bits and a one-entry holding buffer. A word waiting in the
// buffer starts its frame on the edge right after the previous frame's last
// stop bit, so consecutive frames have no idle gap between them.

module uart_tx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  output logic                  Data_Ready,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  stop_bits,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Even parity of a payload word.
  function automatic logic f_xor_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [2:0]            r_state;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_xor;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  logic                  r_par_en;
  logic                  r_stop2;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  r_baud_cnt;
  logic [BCW-1:0]        r_bit_cnt;
  logic                  r_tx;

  logic                  w_accept;
  logic                  w_bit_end;
  logic                  w_last_stop;
  logic                  w_load;
  logic [DIV_WIDTH-1:0]  w_div_eff;

  assign Data_Ready  = ~RST & ~r_hold_full;
  assign w_accept    = Data_Valid & Data_Ready;
  // r_div is only meaningful outside IDLE, where it is at least 1.
  assign w_bit_end   = (r_baud_cnt == (r_div - DIV_WIDTH'(1)));
  assign w_last_stop = (r_state == S_STOP) & w_bit_end &
                       (~r_stop2 | (r_bit_cnt == BCW'(1)));
  // Buffer moves to the shifter when idle, or straight after the final stop bit.
  assign w_load      = r_hold_full & ((r_state == S_IDLE) | w_last_stop);
  assign w_div_eff   = (baud_div == DIV_WIDTH'(0)) ? DIV_WIDTH'(1) : baud_div;

  assign TX_OUT     = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = w_last_stop;

  // Holding buffer: fill on handshake, empty when the frame engine takes it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_hold_xor  <= 1'b0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= P_DATA;
      r_hold_xor  <= f_xor_parity(P_DATA);
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // Frame engine: state, bit timing, config shadow and the registered line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_div      <= '0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_load) begin
      r_state    <= S_START;
      r_tx       <= 1'b0;
      r_shift    <= r_hold_data;
      r_par_bit  <= r_hold_xor ^ parity_type;
      r_par_en   <= parity_enable;
      r_stop2    <= stop_bits;
      r_div      <= w_div_eff;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (r_state == S_IDLE) begin
      r_tx <= 1'b1;
    end else if (!w_bit_end) begin
      r_baud_cnt <= r_baud_cnt + DIV_WIDTH'(1);
    end else begin
      r_baud_cnt <= '0;
      case (r_state)
        S_START: begin
          r_state   <= S_DATA;
          r_bit_cnt <= '0;
          r_tx      <= r_shift[0];
        end
        S_DATA: begin
          if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
            r_bit_cnt <= '0;
            if (r_par_en) begin
              r_state <= S_PARITY;
              r_tx    <= r_par_bit;
            end else begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + BCW'(1);
            r_shift   <= r_shift >> 1;
            r_tx      <= r_shift[1];
          end
        end
        S_PARITY: begin
          r_state   <= S_STOP;
          r_bit_cnt <= '0;
          r_tx      <= 1'b1;
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_last_stop) begin
            r_state <= S_IDLE;
          end else begin
            r_bit_cnt <= BCW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer. A queue-based model expands each
// frame into per-cycle line levels; every cycle the outputs are compared to it.
module tb_uart_tx_framer;

  localparam int DW  = 8;
  localparam int DVW = 16;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [DW-1:0]  P_DATA = '0;
  logic           Data_Valid = 1'b0;
  logic           Data_Ready;
  logic           parity_enable = 1'b0;
  logic           parity_type = 1'b0;
  logic           stop_bits = 1'b0;
  logic [DVW-1:0] baud_div = 16'd4;
  logic           TX_OUT;
  logic           busy;
  logic           frame_done;

  int errors = 0;
  int checks = 0;

  // model: queue of {frame_done, tx} for the current cycle onwards
  logic [1:0]    mq[$];
  logic          m_hold_full = 1'b0;
  logic [DW-1:0] m_hold_word = '0;

  logic cap[0:1023];
  int   cap_n = 0;
  int   busy_low_cnt = 0;
  int   busy_high_cnt = 0;
  int   done_cnt = 0;

  uart_tx_framer #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .Data_Ready(Data_Ready), .parity_enable(parity_enable),
    .parity_type(parity_type), .stop_bits(stop_bits), .baud_div(baud_div),
    .TX_OUT(TX_OUT), .busy(busy), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one rising edge to the model, using the inputs seen at that edge.
  task automatic model_edge();
    logic old_full;
    logic acc;
    logic fb[0:DW+3];
    int   nb;
    int   d;
    old_full = m_hold_full;
    if (RST) begin
      mq.delete();
      m_hold_full = 1'b0;
      return;
    end
    acc = Data_Valid && !old_full;
    if (mq.size() > 0) void'(mq.pop_front());
    if (mq.size() == 0 && old_full) begin
      d  = (baud_div == 0) ? 1 : int'(baud_div);
      nb = 0;
      fb[nb] = 1'b0; nb++;
      for (int i = 0; i < DW; i++) begin fb[nb] = m_hold_word[i]; nb++; end
      if (parity_enable) begin fb[nb] = (^m_hold_word) ^ parity_type; nb++; end
      fb[nb] = 1'b1; nb++;
      if (stop_bits) begin fb[nb] = 1'b1; nb++; end
      for (int b = 0; b < nb; b++)
        for (int c = 0; c < d; c++)
          mq.push_back({(b == nb - 1 && c == d - 1), fb[b]});
      m_hold_full = 1'b0;
    end
    if (acc) begin
      m_hold_full = 1'b1;
      m_hold_word = P_DATA;
    end
  endtask

  // One clock: model update at the edge, full compare at the falling edge.
  task automatic step();
    logic e_tx, e_done, e_busy, e_rdy;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    e_busy = (mq.size() != 0);
    e_tx   = e_busy ? mq[0][0] : 1'b1;
    e_done = e_busy ? mq[0][1] : 1'b0;
    e_rdy  = !RST && !m_hold_full;
    check("tx_out", {31'd0, TX_OUT}, {31'd0, e_tx});
    check("busy", {31'd0, busy}, {31'd0, e_busy});
    check("frame_done", {31'd0, frame_done}, {31'd0, e_done});
    check("data_ready", {31'd0, Data_Ready}, {31'd0, e_rdy});
    if (cap_n < 1024) cap[cap_n] = TX_OUT;
    cap_n++;
    if (!busy) busy_low_cnt++;
    if (busy) busy_high_cnt++;
    if (frame_done) done_cnt++;
  endtask

  task automatic send(input logic [DW-1:0] d, input int limit, output int n);
    logic r;
    Data_Valid = 1'b1;
    P_DATA = d;
    n = 0;
    r = 1'b0;
    while (!r && n < limit) begin
      r = Data_Ready;
      step();
      n++;
    end
    Data_Valid = 1'b0;
    check("send_accepted", {31'd0, r}, 32'd1);
  endtask

  task automatic run_until_done(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < limit);
    check("done_within_limit", {31'd0, frame_done}, 32'd1);
  endtask

  initial begin
    int n, n1, n2;
    logic [10:0] v11;
    logic [11:0] v12;
    logic r, saw_done;

    // reset state
    step(); step();
    check("rst_tx", {31'd0, TX_OUT}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_ready", {31'd0, Data_Ready}, 32'd0);
    RST = 1'b0;
    step();
    check("post_rst_ready", {31'd0, Data_Ready}, 32'd1);

    // 0xA5, D=4, even parity, one stop
    baud_div = 16'd4; parity_enable = 1'b1; parity_type = 1'b0; stop_bits = 1'b0;
    send(8'hA5, 10, n);
    cap_n = 0;
    run_until_done(200, n);
    check("t1_len", n, 32'd44);
    for (int i = 0; i < 11; i++) v11[i] = cap[i*4+1];
    check("t1_bits", {21'd0, v11}, {21'd0, 11'b10101001010});
    step();
    check("t1_busy_fall", {31'd0, busy}, 32'd0);

    // 0x01, odd parity, two stops
    parity_type = 1'b1; stop_bits = 1'b1;
    send(8'h01, 10, n);
    cap_n = 0;
    run_until_done(200, n);
    check("t2_len", n, 32'd48);
    for (int i = 0; i < 12; i++) v12[i] = cap[i*4+1];
    check("t2_bits", {20'd0, v12}, {20'd0, 12'b110000000010});
    step();
    check("t2_busy_fall", {31'd0, busy}, 32'd0);

    // back-to-back frames
    parity_type = 1'b0; stop_bits = 1'b0;
    send(8'h55, 10, n);
    send(8'h0F, 20, n);
    check("t3_second_accept_lat", n, 32'd2);
    busy_low_cnt = 0;
    run_until_done(100, n1);
    run_until_done(100, n2);
    check("t3_gap", n2, 32'd44);
    check("t3_no_idle", busy_low_cnt, 32'd0);
    step();
    check("t3_busy_fall", {31'd0, busy}, 32'd0);

    // D=1 continuous stream
    baud_div = 16'd0; parity_enable = 1'b0;
    Data_Valid = 1'b1; P_DATA = 8'h3C;
    run_until_done(50, n);
    busy_low_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      run_until_done(50, n);
      check("t4_gap", n, 32'd10);
    end
    check("t4_no_idle", busy_low_cnt, 32'd0);
    Data_Valid = 1'b0;
    for (int k = 0; k < 40; k++) step();
    check("t4_drained", {31'd0, busy}, 32'd0);

    // buffer full backpressure
    baud_div = 16'd4;
    send(8'h11, 10, n);
    send(8'h22, 10, n);
    Data_Valid = 1'b1; P_DATA = 8'h33;
    for (int k = 0; k < 5; k++) step();
    check("t5_ready_low", {31'd0, Data_Ready}, 32'd0);
    n = 0; r = 1'b0; saw_done = 1'b0;
    while (!r && n < 200) begin
      r = Data_Ready;
      step();
      n++;
      if (frame_done) saw_done = 1'b1;
    end
    Data_Valid = 1'b0;
    check("t5_accepted", {31'd0, r}, 32'd1);
    check("t5_after_frame1", {31'd0, saw_done}, 32'd1);
    n = 0;
    while (busy && n < 300) begin step(); n++; end
    check("t5_drained", {31'd0, busy}, 32'd0);

    // config change mid-frame only affects the next frame
    parity_enable = 1'b1;
    send(8'hA5, 10, n);
    for (int k = 0; k < 10; k++) step();
    baud_div = 16'd8;
    run_until_done(200, n);
    check("t6_old_div_len", n + 10, 32'd44);
    send(8'hA5, 10, n);
    run_until_done(200, n);
    check("t6_new_div_len", n, 32'd88);
    step();
    baud_div = 16'd4; parity_enable = 1'b0;

    // reset mid-DATA with a word buffered
    send(8'hFF, 10, n);
    send(8'h44, 10, n);
    for (int k = 0; k < 15; k++) step();
    check("t7_busy_before", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    #1;
    check("t7_ready_in_rst", {31'd0, Data_Ready}, 32'd0);
    step();
    check("t7_tx_rst", {31'd0, TX_OUT}, 32'd1);
    check("t7_busy_rst", {31'd0, busy}, 32'd0);
    check("t7_done_rst", {31'd0, frame_done}, 32'd0);
    RST = 1'b0;
    done_cnt = 0; busy_high_cnt = 0;
    for (int k = 0; k < 60; k++) step();
    check("t7_no_done", done_cnt, 32'd0);
    check("t7_stay_idle", busy_high_cnt, 32'd0);
    check("t7_ready_after", {31'd0, Data_Ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
